// File: rtl/syn_lb_master.sv
// Local-bus initiator: turns a command stream into single LB read/write transactions, one outstanding, with a response watchdog.
// Optional statistics counters are built only when SYN_LB_MASTER_STATS_EN is defined.
module syn_lb_master #(
    parameter int P_LB_DATA_W   = 32,
    parameter int P_LB_ADDR_W   = 12,
    parameter int P_TIMEOUT_W   = 8,
    parameter int P_TIMEOUT_VAL = 200
) (
    input  logic                   clk_ir,
    input  logic                   rst_il,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_wr,
    input  logic [P_LB_ADDR_W-1:0] cmd_addr,
    input  logic [P_LB_DATA_W-1:0] cmd_wdata,
    output logic                   rsp_valid,
    output logic [P_LB_DATA_W-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic                   lb_wr_en,
    output logic                   lb_rd_en,
    output logic [P_LB_ADDR_W-1:0] lb_addr,
    output logic [P_LB_DATA_W-1:0] lb_wr_data,
    input  logic                   lb_wr_valid,
    input  logic                   lb_rd_valid,
    input  logic [P_LB_DATA_W-1:0] lb_rd_data,
    output logic                   busy,
    output logic [15:0]            stat_txn_cnt,
    output logic [15:0]            stat_tout_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RSP
    } state_t;

    localparam logic [P_TIMEOUT_W-1:0] TOUT_LAST = P_TIMEOUT_W'(P_TIMEOUT_VAL - 1);

    state_t                  state_reg, state_next;
    logic [P_TIMEOUT_W-1:0]  wd_reg, wd_next;
    logic                    is_wr_reg, is_wr_next;
    logic                    cmd_ready_reg, cmd_ready_next;
    logic                    wr_en_reg, wr_en_next;
    logic                    rd_en_reg, rd_en_next;
    logic [P_LB_ADDR_W-1:0]  addr_reg, addr_next;
    logic [P_LB_DATA_W-1:0]  wdata_reg, wdata_next;
    logic                    rsp_valid_reg, rsp_valid_next;
    logic [P_LB_DATA_W-1:0]  rdata_reg, rdata_next;
    logic                    err_reg, err_next;
    logic                    match_valid;

    // Only the acknowledge that matches the issued transaction type counts.
    assign match_valid = is_wr_reg ? lb_wr_valid : lb_rd_valid;

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state_reg     <= ST_IDLE;
            wd_reg        <= '0;
            is_wr_reg     <= 1'b0;
            cmd_ready_reg <= 1'b1;
            wr_en_reg     <= 1'b0;
            rd_en_reg     <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rdata_reg     <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wd_reg        <= wd_next;
            is_wr_reg     <= is_wr_next;
            cmd_ready_reg <= cmd_ready_next;
            wr_en_reg     <= wr_en_next;
            rd_en_reg     <= rd_en_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            rsp_valid_reg <= rsp_valid_next;
            rdata_reg     <= rdata_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wd_next        = wd_reg;
        is_wr_next     = is_wr_reg;
        cmd_ready_next = cmd_ready_reg;
        wr_en_next     = 1'b0;
        rd_en_next     = 1'b0;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        rsp_valid_next = 1'b0;
        rdata_next     = rdata_reg;
        err_next       = err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    is_wr_next     = cmd_wr;
                    addr_next      = cmd_addr;
                    wdata_next     = cmd_wdata;
                    wr_en_next     = cmd_wr;
                    rd_en_next     = !cmd_wr;
                    cmd_ready_next = 1'b0;
                    state_next     = ST_REQ;
                end
            end
            ST_REQ: begin
                wd_next = '0;
                // A zero-latency responder acknowledges alongside the strobe.
                if (match_valid) begin
                    rdata_next     = is_wr_reg ? '0 : lb_rd_data;
                    err_next       = 1'b0;
                    rsp_valid_next = 1'b1;
                    state_next     = ST_RSP;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wd_next = wd_reg + P_TIMEOUT_W'(1);
                if (match_valid) begin
                    rdata_next     = is_wr_reg ? '0 : lb_rd_data;
                    err_next       = 1'b0;
                    rsp_valid_next = 1'b1;
                    state_next     = ST_RSP;
                end else if (wd_reg == TOUT_LAST) begin
                    rdata_next     = '0;
                    err_next       = 1'b1;
                    rsp_valid_next = 1'b1;
                    state_next     = ST_RSP;
                end
            end
            ST_RSP: begin
                cmd_ready_next = 1'b1;
                state_next     = ST_IDLE;
            end
            default: begin
                cmd_ready_next = 1'b1;
                state_next     = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready  = cmd_ready_reg;
    assign lb_wr_en   = wr_en_reg;
    assign lb_rd_en   = rd_en_reg;
    assign lb_addr    = addr_reg;
    assign lb_wr_data = wdata_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_rdata  = rdata_reg;
    assign rsp_err    = err_reg;
    assign busy       = (state_reg != ST_IDLE);

`ifdef SYN_LB_MASTER_STATS_EN
    logic [15:0] txn_cnt_reg;
    logic [15:0] tout_cnt_reg;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            txn_cnt_reg  <= '0;
            tout_cnt_reg <= '0;
        end else if (rsp_valid_reg) begin
            if (txn_cnt_reg != 16'hFFFF) begin
                txn_cnt_reg <= txn_cnt_reg + 16'd1;
            end
            if (err_reg && (tout_cnt_reg != 16'hFFFF)) begin
                tout_cnt_reg <= tout_cnt_reg + 16'd1;
            end
        end
    end

    assign stat_txn_cnt  = txn_cnt_reg;
    assign stat_tout_cnt = tout_cnt_reg;
`else
    assign stat_txn_cnt  = '0;
    assign stat_tout_cnt = '0;
`endif

endmodule

// File: tb/tb_syn_lb_master.sv
// Scoreboard bench for syn_lb_master: directed commands push expected responses; a monitor checks each rsp_valid.
module tb_syn_lb_master;

    logic        clk_ir;
    logic        rst_il;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        lb_wr_en;
    logic        lb_rd_en;
    logic [11:0] lb_addr;
    logic [31:0] lb_wr_data;
    logic        lb_wr_valid;
    logic        lb_rd_valid;
    logic [31:0] lb_rd_data;
    logic        busy;
    logic [15:0] stat_txn_cnt;
    logic [15:0] stat_tout_cnt;

    logic        auto_resp;
    logic        man_wr_valid;
    logic        man_rd_valid;
    logic [31:0] man_rd_data;

`ifdef SYN_LB_MASTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Zero-latency responder for back-to-back traffic, otherwise driven by hand.
    assign lb_wr_valid = (auto_resp && lb_wr_en) || man_wr_valid;
    assign lb_rd_valid = (auto_resp && lb_rd_en) || man_rd_valid;
    assign lb_rd_data  = auto_resp ? {20'hABCDE, lb_addr} : man_rd_data;

    syn_lb_master #(
        .P_LB_DATA_W  (32),
        .P_LB_ADDR_W  (12),
        .P_TIMEOUT_W  (8),
        .P_TIMEOUT_VAL(200)
    ) dut (
        .clk_ir       (clk_ir),
        .rst_il       (rst_il),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_wr       (cmd_wr),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .lb_wr_en     (lb_wr_en),
        .lb_rd_en     (lb_rd_en),
        .lb_addr      (lb_addr),
        .lb_wr_data   (lb_wr_data),
        .lb_wr_valid  (lb_wr_valid),
        .lb_rd_valid  (lb_rd_valid),
        .lb_rd_data   (lb_rd_data),
        .busy         (busy),
        .stat_txn_cnt (stat_txn_cnt),
        .stat_tout_cnt(stat_tout_cnt)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    int   wr_pulses = 0;
    int   rd_pulses = 0;
    int   both_pulses = 0;
    int   n_rsp = 0;

    initial begin
        clk_ir = 1'b0;
        forever #5 clk_ir = ~clk_ir;
    end

    initial forever begin
        @(posedge clk_ir);
        cyc++;
    end

    initial forever begin
        @(negedge clk_ir);
        if (lb_wr_en === 1'b1) wr_pulses++;
        if (lb_rd_en === 1'b1) rd_pulses++;
        if ((lb_wr_en === 1'b1) && (lb_rd_en === 1'b1)) both_pulses++;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Response monitor: every rsp_valid must match the oldest expectation.
    initial forever begin
        exp_t e;
        @(negedge clk_ir);
        if (rsp_valid === 1'b1) begin
            n_rsp++;
            $display("rsp %0d: cycle %0d rdata=0x%08h err=%0b", n_rsp, cyc, rsp_rdata, rsp_err);
            check("rsp_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk_ir);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] rdata, input logic err, input int at_cyc);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.cyc   = at_cyc;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic wr, input logic [11:0] addr, input logic [31:0] wdata, output int s);
        int waited;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("ready_before_cmd", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        tick();
        cmd_valid = 1'b0;
        s = cyc;
        check("strobe_wr", 32'(lb_wr_en), 32'(wr));
        check("strobe_rd", 32'(lb_rd_en), 32'(!wr));
        check("lb_addr", 32'(lb_addr), 32'(addr));
        check("lb_wr_data", lb_wr_data, wdata);
        check("busy_req", 32'(busy), 1);
        check("ready_drop", 32'(cmd_ready), 0);
    endtask

    initial begin
        int s;
        int n;
        int w0;
        int r0;
        int acc[4];
        logic        b_wr[4]    = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [11:0] b_addr[4]  = '{12'h010, 12'h020, 12'h030, 12'h040};
        logic [31:0] b_wdata[4] = '{32'h1111_0000, 32'h0, 32'h3333_0000, 32'h0};
        logic [31:0] b_rdata[4] = '{32'h0, 32'hABCD_E020, 32'h0, 32'hABCD_E040};

        rst_il = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        auto_resp = 1'b0;
        man_wr_valid = 1'b0;
        man_rd_valid = 1'b0;
        man_rd_data = '0;

        // Reset state
        tick();
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_strobes", 32'({lb_wr_en, lb_rd_en}), 0);
        check("rst_lb_addr", 32'(lb_addr), 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        rst_il = 1'b1;
        tick();
        tick();

        // Write, responder acknowledges 3 cycles after the strobe
        w0 = wr_pulses;
        issue(1'b1, 12'h105, 32'hA5A5_0001, s);
        tick();
        check("wr_single_pulse", 32'(lb_wr_en), 0);
        tick();
        tick();
        man_wr_valid = 1'b1;
        push_exp(32'h0, 1'b0, cyc + 1);
        tick();
        man_wr_valid = 1'b0;
        check("wr_addr_held", 32'(lb_addr), 32'h105);
        check("wr_data_held", lb_wr_data, 32'hA5A5_0001);
        tick();
        check("wr_idle_ready", 32'(cmd_ready), 1);
        check("wr_idle_busy", 32'(busy), 0);
        check("wr_addr_kept", 32'(lb_addr), 32'h105);
        check("wr_pulse_count", wr_pulses - w0, 1);

        // Read with zero-latency responder
        r0 = rd_pulses;
        issue(1'b0, 12'h2F0, 32'h0, s);
        man_rd_valid = 1'b1;
        man_rd_data  = 32'h1234_5678;
        push_exp(32'h1234_5678, 1'b0, s + 1);
        tick();
        man_rd_valid = 1'b0;
        check("rd_ready_in_rsp", 32'(cmd_ready), 0);
        tick();
        check("rd_ready_rise", 32'(cmd_ready), 1);
        check("rd_pulse_count", rd_pulses - r0, 1);

        // Timeout: no responder, garbage on the read bus
        man_rd_data = 32'hDEAD_BEEF;
        issue(1'b0, 12'h3A0, 32'h0, s);
        push_exp(32'h0, 1'b1, s + 201);
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check("tout_completed", 32'(busy), 0);
        check("stat_tout_cnt", 32'(stat_tout_cnt), STATS ? 1 : 0);
        check("stat_txn_cnt_3", 32'(stat_txn_cnt), STATS ? 3 : 0);

        // Stray and wrong-type valids
        man_rd_valid = 1'b1;
        tick();
        man_rd_valid = 1'b0;
        tick();
        check("stray_idle_busy", 32'(busy), 0);
        issue(1'b0, 12'h0C4, 32'h0, s);
        man_wr_valid = 1'b1;
        tick();
        man_wr_valid = 1'b0;
        tick();
        man_wr_valid = 1'b1;
        tick();
        man_wr_valid = 1'b0;
        check("wrongtype_busy", 32'(busy), 1);
        tick();
        man_rd_valid = 1'b1;
        man_rd_data  = 32'h0BAD_F00D;
        push_exp(32'h0BAD_F00D, 1'b0, cyc + 1);
        tick();
        man_rd_valid = 1'b0;
        man_wr_valid = 1'b1;
        tick();
        man_wr_valid = 1'b0;
        check("stray_done_busy", 32'(busy), 0);
        tick();

        // Reset in the middle of WAIT
        issue(1'b0, 12'h1FF, 32'h0, s);
        repeat (5) tick();
        check("mid_wait_busy", 32'(busy), 1);
        rst_il = 1'b0;
        #1;
        check("arst_strobes", 32'({lb_wr_en, lb_rd_en}), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_rsp_valid", 32'(rsp_valid), 0);
        check("arst_cmd_ready", 32'(cmd_ready), 1);
        tick();
        tick();
        rst_il = 1'b1;
        repeat (10) tick();
        check("post_rst_busy", 32'(busy), 0);

        // Back-to-back with cmd_valid held high
        auto_resp = 1'b1;
        cmd_valid = 1'b1;
        cmd_wr    = b_wr[0];
        cmd_addr  = b_addr[0];
        cmd_wdata = b_wdata[0];
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!cmd_ready && n < 10) begin
                tick();
                n++;
            end
            check("b2b_ready", 32'(cmd_ready), 1);
            acc[i] = cyc;
            push_exp(b_rdata[i], 1'b0, cyc + 2);
            if (i > 0) check("b2b_period", acc[i] - acc[i-1], 3);
            tick();
            if (i < 3) begin
                cmd_wr    = b_wr[i+1];
                cmd_addr  = b_addr[i+1];
                cmd_wdata = b_wdata[i+1];
            end else begin
                cmd_valid = 1'b0;
            end
        end
        repeat (4) tick();
        auto_resp = 1'b0;
        check("stat_txn_cnt_4", 32'(stat_txn_cnt), STATS ? 4 : 0);
        check("stat_tout_after_rst", 32'(stat_tout_cnt), 0);

        check("never_both_strobes", both_pulses, 0);
        check("missing_rsp", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

endmodule
